// File: rtl/driver_stats_pkg.sv
// Shared types, frame layout and length helpers for the driver statistics reader.
// Latency: n/a (definitions only). Backpressure: n/a. Honours DRIVER_STATS_CHECKSUM_EN.
package driver_stats_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam logic [15:0] HDR_TAG_DEF  = 16'hD5A7;
    localparam int          DEF_NUM_BINS = 16;

    localparam int HDR_IDX   = 0;
    localparam int ADDR_BASE = 1;

    function automatic int vctr_base(input int nb);
        return ADDR_BASE + nb / 2;
    endfunction

    function automatic int occ_idx(input int nb);
        return vctr_base(nb) + nb / 2;
    endfunction

    function automatic int cyc_idx(input int nb);
        return occ_idx(nb) + 1;
    endfunction

    // Trailing checksum word, when enabled, adds one word after the cycle counters.
    function automatic int frame_len(input int nb);
`ifdef DRIVER_STATS_CHECKSUM_EN
        return nb + 4;
`else
        return nb + 3;
`endif
    endfunction

    localparam int VCTR_BASE = vctr_base(DEF_NUM_BINS);
    localparam int OCC_IDX   = occ_idx(DEF_NUM_BINS);
    localparam int CYC_IDX   = cyc_idx(DEF_NUM_BINS);

endpackage

// File: rtl/driver_stats_reader_if.sv
// 32-bit statistics stream toward the host register/DMA path.
// Latency: n/a (wiring only). Backpressure: stat_tready from the slave stalls the master.
interface driver_stats_reader_if;

    logic [31:0] stat_tdata;
    logic        stat_tvalid;
    logic        stat_tready;
    logic        stat_tlast;

    modport master (
        output stat_tdata,
        output stat_tvalid,
        output stat_tlast,
        input  stat_tready
    );

    modport slave (
        input  stat_tdata,
        input  stat_tvalid,
        input  stat_tlast,
        output stat_tready
    );

endinterface

// File: rtl/driver_stats_snapshot.sv
// Capture register bank for one statistics frame plus a word-select mux by frame index.
// Latency: capture on the i_cap edge, word select combinational. Backpressure: none (index held by caller).
module driver_stats_snapshot
    import driver_stats_pkg::*;
#(
    parameter int          NUM_BINS = DEF_NUM_BINS,
    parameter logic [15:0] HDR_TAG  = HDR_TAG_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_cap,
    input  logic [7:0]              i_seq,
    input  logic [16*NUM_BINS-1:0]  i_addr_bins,
    input  logic [16*NUM_BINS-1:0]  i_vctr_bins,
    input  logic [15:0]             i_addr_cyc,
    input  logic [15:0]             i_vctr_cyc,
    input  logic [15:0]             i_occ_addr,
    input  logic [15:0]             i_occ_vctr,
    input  logic [7:0]              i_idx,
    output logic [31:0]             o_word
);

    localparam int          OW    = $clog2(16 * NUM_BINS);
    localparam logic [7:0]  L_HDR = 8'(HDR_IDX);
    localparam logic [7:0]  L_AB  = 8'(ADDR_BASE);
    localparam logic [7:0]  L_VB  = 8'(vctr_base(NUM_BINS));
    localparam logic [7:0]  L_OCC = 8'(occ_idx(NUM_BINS));
    localparam logic [7:0]  L_CYC = 8'(cyc_idx(NUM_BINS));
    localparam logic [7:0]  L_LEN = 8'(frame_len(NUM_BINS));

    logic [16*NUM_BINS-1:0] r_addr;
    logic [16*NUM_BINS-1:0] r_vctr;
    logic [31:0]            r_occ;
    logic [31:0]            r_cyc;
    logic [7:0]             r_seq;

    logic [7:0]             w_k;
    logic [OW-1:0]          w_off;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_vctr <= '0;
            r_occ  <= '0;
            r_cyc  <= '0;
            r_seq  <= '0;
        end else if (i_cap) begin
            r_addr <= i_addr_bins;
            r_vctr <= i_vctr_bins;
            r_occ  <= {i_occ_vctr, i_occ_addr};
            r_cyc  <= {i_vctr_cyc, i_addr_cyc};
            r_seq  <= i_seq;
        end
    end

    // Bin pair k occupies bits [32k+31:32k], so the odd bin lands in the upper half.
    always_comb begin
        w_k = '0;
        if (i_idx >= L_VB) w_k = i_idx - L_VB;
        else               w_k = i_idx - L_AB;
    end

    assign w_off = OW'({w_k, 5'd0});

    always_comb begin
        o_word = '0;
        if (i_idx == L_HDR)      o_word = {HDR_TAG, r_seq, L_LEN};
        else if (i_idx < L_VB)   o_word = r_addr[w_off +: 32];
        else if (i_idx < L_OCC)  o_word = r_vctr[w_off +: 32];
        else if (i_idx == L_OCC) o_word = r_occ;
        else if (i_idx == L_CYC) o_word = r_cyc;
    end

endmodule

// File: rtl/driver_stats_reader.sv
// Single-cycle statistics snapshot streamed as a framed 32-bit valid/ready sequence (DRIVER_STATS_CHECKSUM_EN adds an XOR trailer).
// Latency: first word valid one cycle after the accepted snap_req. Backpressure: words hold stable while stat_tready is low.
module driver_stats_reader
    import driver_stats_pkg::*;
#(
    parameter int          NUM_BINS = DEF_NUM_BINS,
    parameter logic [15:0] HDR_TAG  = HDR_TAG_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    snap_req,
    input  logic [16*NUM_BINS-1:0]  addr_bins,
    input  logic [16*NUM_BINS-1:0]  vctr_bins,
    input  logic [15:0]             addr_cycle_cnt,
    input  logic [15:0]             vctr_cycle_cnt,
    input  logic [15:0]             words_in_addr_fifo,
    input  logic [15:0]             words_in_vctr_fifo,
    driver_stats_reader_if.master   strm,
    output logic                    busy,
    output logic [7:0]              snap_seq,
    output logic [7:0]              drop_cnt
);

    localparam logic [7:0] L_CYC = 8'(cyc_idx(NUM_BINS));

    state_t      r_state;
    state_t      w_nxt;
    logic [7:0]  r_idx;
    logic [7:0]  r_seq;
    logic [7:0]  r_drop;
    logic        w_xfer;
    logic        w_cap;
    logic        w_last_dat;
    logic [31:0] w_word;

    driver_stats_snapshot #(
        .NUM_BINS (NUM_BINS),
        .HDR_TAG  (HDR_TAG)
    ) u_snap (
        .clk         (clk),
        .reset       (reset),
        .i_cap       (w_cap),
        .i_seq       (r_seq + 8'd1),
        .i_addr_bins (addr_bins),
        .i_vctr_bins (vctr_bins),
        .i_addr_cyc  (addr_cycle_cnt),
        .i_vctr_cyc  (vctr_cycle_cnt),
        .i_occ_addr  (words_in_addr_fifo),
        .i_occ_vctr  (words_in_vctr_fifo),
        .i_idx       (r_idx),
        .o_word      (w_word)
    );

    assign w_xfer     = strm.stat_tvalid & strm.stat_tready;
    assign w_last_dat = (r_idx == L_CYC);

    always_comb begin
        w_nxt = r_state;
        w_cap = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_nxt = SEND;
                    w_cap = 1'b1;
                end
            end
            SEND: begin
                if (w_xfer && w_last_dat) begin
`ifdef DRIVER_STATS_CHECKSUM_EN
                    w_nxt = CSUM;
`else
                    w_nxt = IDLE;
`endif
                end
            end
`ifdef DRIVER_STATS_CHECKSUM_EN
            CSUM: begin
                if (w_xfer) w_nxt = IDLE;
            end
`endif
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_seq   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_cap) begin
                r_idx <= '0;
                r_seq <= r_seq + 8'd1;
            end else if (w_xfer && (r_state == SEND)) begin
                r_idx <= r_idx + 8'd1;
            end
            if (snap_req && (r_state != IDLE) && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

`ifdef DRIVER_STATS_CHECKSUM_EN
    logic [31:0] r_csum;

    // Folded in at each accepted data word so the trailer covers exactly what left the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              r_csum <= '0;
        else if (w_cap)                          r_csum <= '0;
        else if (w_xfer && (r_state == SEND))    r_csum <= r_csum ^ w_word;
    end
`endif

    // Outputs decode straight from state so a reset drops tvalid without waiting for a clock.
    always_comb begin
        strm.stat_tvalid = (r_state != IDLE);
        strm.stat_tlast  = 1'b0;
        strm.stat_tdata  = '0;
        case (r_state)
            SEND: begin
                strm.stat_tdata = w_word;
`ifndef DRIVER_STATS_CHECKSUM_EN
                strm.stat_tlast = w_last_dat;
`endif
            end
`ifdef DRIVER_STATS_CHECKSUM_EN
            CSUM: begin
                strm.stat_tdata = r_csum;
                strm.stat_tlast = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy     = (r_state != IDLE);
    assign snap_seq = r_seq;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_driver_stats_reader.sv
// Directed bench for driver_stats_reader: framing, stalls, capture isolation, drops, seq wrap, reset abort.
// Honours DRIVER_STATS_CHECKSUM_EN for the longer frame and XOR trailer.
module tb_driver_stats_reader;

    localparam int NB = 16;
`ifdef DRIVER_STATS_CHECKSUM_EN
    localparam int          L      = 20;
    localparam logic [31:0] EXP_W0 = 32'hD5A7_0114;
`else
    localparam int          L      = 19;
    localparam logic [31:0] EXP_W0 = 32'hD5A7_0113;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             snap_req;
    logic [16*NB-1:0] addr_bins;
    logic [16*NB-1:0] vctr_bins;
    logic [15:0]      addr_cyc, vctr_cyc, occ_a, occ_v;
    logic             busy;
    logic [7:0]       snap_seq, drop_cnt;

    logic [15:0] ab [NB];
    logic [15:0] vb [NB];

    logic [31:0] frame_q [$];
    logic [31:0] exp_q   [$];
    logic [31:0] s1_q    [$];
    logic [7:0]  exp_seq;
    int          checks = 0;
    int          errors = 0;

    driver_stats_reader_if sif ();

    driver_stats_reader #(
        .NUM_BINS (NB),
        .HDR_TAG  (16'hD5A7)
    ) dut (
        .clk                (clk),
        .reset              (rst_n),
        .snap_req           (snap_req),
        .addr_bins          (addr_bins),
        .vctr_bins          (vctr_bins),
        .addr_cycle_cnt     (addr_cyc),
        .vctr_cycle_cnt     (vctr_cyc),
        .words_in_addr_fifo (occ_a),
        .words_in_vctr_fifo (occ_v),
        .strm               (sif),
        .busy               (busy),
        .snap_seq           (snap_seq),
        .drop_cnt           (drop_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        addr_bins = '0;
        vctr_bins = '0;
        for (int i = 0; i < NB; i++) begin
            addr_bins[16*i +: 16] = ab[i];
            vctr_bins[16*i +: 16] = vb[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_pattern();
        for (int i = 0; i < NB; i++) begin
            ab[i] = 16'h0100 + 16'(i);
            vb[i] = 16'h0200 + 16'(i);
        end
        occ_a = 16'd5; occ_v = 16'd7; addr_cyc = 16'd3; vctr_cyc = 16'd9;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NB; i++) begin
            ab[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
        occ_a = 16'($urandom); occ_v = 16'($urandom);
        addr_cyc = 16'($urandom); vctr_cyc = 16'($urandom);
    endtask

    function automatic void build_exp(input logic [7:0] seq);
        logic [31:0] x;
        exp_q.delete();
        exp_q.push_back({16'hD5A7, seq, 8'(L)});
        for (int k = 0; k < NB/2; k++) exp_q.push_back({ab[2*k+1], ab[2*k]});
        for (int k = 0; k < NB/2; k++) exp_q.push_back({vb[2*k+1], vb[2*k]});
        exp_q.push_back({occ_v, occ_a});
        exp_q.push_back({vctr_cyc, addr_cyc});
`ifdef DRIVER_STATS_CHECKSUM_EN
        x = '0;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endfunction

    task automatic do_snap();
        @(negedge clk);
        sif.stat_tready = 1'b0;
        snap_req = 1'b1;
        exp_seq = exp_seq + 8'd1;
        build_exp(exp_seq);
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // mode: 0 always ready, 1 ready 1-0-0-1 then random; pulses: 1 mid-frame, 2 on the final transfer
    task automatic get_frame(input int mode, input bit scramble, input int pulses);
        logic [32:0] held;
        bit          held_v;
        bit          done;
        int          cyc;
        logic        pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        frame_q.delete();
        held_v = 1'b0; done = 1'b0; cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (scramble) scramble_inputs();
            snap_req = (pulses == 1) && (cyc == 2 || cyc == 4 || cyc == 6);
            if (mode == 0)     sif.stat_tready = 1'b1;
            else if (cyc <= 8) sif.stat_tready = pat[(cyc-1) % 4];
            else               sif.stat_tready = 1'($urandom_range(0, 1));
            chk("tvalid_mid_frame", {31'd0, sif.stat_tvalid}, 32'd1);
            if (held_v) chk("stall_hold", {31'd0, sif.stat_tlast} ^ (held[32] ? 32'd1 : 32'd0), 32'd0);
            if (held_v) chk("stall_data", sif.stat_tdata, held[31:0]);
            if (sif.stat_tvalid && sif.stat_tready) begin
                frame_q.push_back(sif.stat_tdata);
                chk("tlast_pos", {31'd0, sif.stat_tlast}, (frame_q.size() == L) ? 32'd1 : 32'd0);
                held_v = 1'b0;
                if (sif.stat_tlast || frame_q.size() >= L) done = 1'b1;
                if (pulses == 2 && done) snap_req = 1'b1;
            end else begin
                held   = {sif.stat_tlast, sif.stat_tdata};
                held_v = 1'b1;
            end
        end
        chk("frame_done", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        snap_req = 1'b0;
        sif.stat_tready = 1'b0;
        chk("post_tvalid", {31'd0, sif.stat_tvalid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, "_len"}, 32'(frame_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < L; i++)
            chk($sformatf("%s_w%0d", tag, i), (i < frame_q.size()) ? frame_q[i] : 32'hxxxx_xxxx, exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0; snap_req = 1'b0; sif.stat_tready = 1'b0; exp_seq = 8'd0;
        set_pattern();
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {31'd0, sif.stat_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, sif.stat_tlast},  32'd0);
        chk("rst_tdata",  sif.stat_tdata, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_seq",    {24'd0, snap_seq}, 32'd0);
        chk("rst_drop",   {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tvalid", {31'd0, sif.stat_tvalid}, 32'd0);

        // Unstalled reference frame
        do_snap();
        chk("s1_busy",   {31'd0, busy}, 32'd1);
        chk("s1_tvalid", {31'd0, sif.stat_tvalid}, 32'd1);
        get_frame(0, 1'b0, 0);
        finish_frame();
        compare_frame("s1");
        chk("s1_w0",  frame_q[0],  EXP_W0);
        chk("s1_w1",  frame_q[1],  32'h0101_0100);
        chk("s1_w9",  frame_q[9],  32'h0201_0200);
        chk("s1_w17", frame_q[17], 32'h0007_0005);
        chk("s1_w18", frame_q[18], 32'h0009_0003);
        s1_q = frame_q;

        // Stalled consumer
        do_snap();
        get_frame(1, 1'b0, 0);
        finish_frame();
        compare_frame("s2");
        for (int i = 1; i < L; i++) chk($sformatf("s2_same_w%0d", i), frame_q[i], s1_q[i]);

        // Inputs churn during SEND
        do_snap();
        get_frame(0, 1'b1, 0);
        finish_frame();
        compare_frame("s3");
        set_pattern();

        // Three requests while busy
        do_snap();
        get_frame(0, 1'b0, 1);
        finish_frame();
        compare_frame("s4");
        repeat (3) begin
            @(negedge clk);
            chk("s4_no_second", {31'd0, sif.stat_tvalid}, 32'd0);
        end
        chk("s4_drop", {24'd0, drop_cnt}, 32'd3);
        chk("s4_seq",  {24'd0, snap_seq}, 32'd4);

        // Request on the final transfer cycle is dropped
        do_snap();
        get_frame(0, 1'b0, 2);
        finish_frame();
        repeat (2) begin
            @(negedge clk);
            chk("s5_no_frame", {31'd0, sif.stat_tvalid}, 32'd0);
        end
        chk("s5_drop", {24'd0, drop_cnt}, 32'd4);
        chk("s5_seq",  {24'd0, snap_seq}, 32'd5);

        // Run captures until the sequence wraps to 0
        while (exp_seq != 8'd0) begin
            do_snap();
            get_frame(0, 1'b0, 0);
            chk("wrap_hdr", frame_q[0], exp_q[0]);
        end
        finish_frame();
        chk("wrap_seq",  {24'd0, snap_seq}, 32'd0);
        chk("wrap_hdr0", frame_q[0], {16'hD5A7, 8'h00, 8'(L)});

        // Reset while word 7 is on the bus
        do_snap();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sif.stat_tready = 1'b1;
        end
        @(negedge clk);
        chk("rst7_word", sif.stat_tdata, exp_q[7]);
        rst_n = 1'b0;
        #1;
        chk("rst7_tvalid", {31'd0, sif.stat_tvalid}, 32'd0);
        chk("rst7_tlast",  {31'd0, sif.stat_tlast},  32'd0);
        chk("rst7_tdata",  sif.stat_tdata, 32'd0);
        chk("rst7_busy",   {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_seq = 8'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst7_quiet", {31'd0, sif.stat_tvalid}, 32'd0);
        end
        do_snap();
        chk("rst7_hdr", sif.stat_tdata, {16'hD5A7, 8'h01, 8'(L)});
        get_frame(0, 1'b0, 0);
        finish_frame();
        compare_frame("rst7_new");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
